// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side and issue-side handshake bundle for decode_queue
// slave  : the decode stage (takes in_*, out_ready and flush; drives in_ready, rf_rs*, out_*)
// master : the fetch/issue environment driving the stage
interface decode_queue_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [4:0]  rf_rs1;
  logic [4:0]  rf_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  out_kind;
  logic [2:0]  out_funct3;
  logic        out_alt;
  logic        out_mext;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [31:0] out_imm;
  logic [2:0]  out_count;
  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, rf_rs1, rf_rs2, out_valid, out_pc, out_kind, out_funct3,
           out_alt, out_mext, out_rd, out_rs1, out_rs2, out_imm, out_count
  );
  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, rf_rs1, rf_rs2, out_valid, out_pc, out_kind, out_funct3,
           out_alt, out_mext, out_rd, out_rs1, out_rs2, out_imm, out_count
  );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: RV32I decode stage with valid/ready input and a DEPTH-entry queue of decoded records
// clk  : clock
// rstn : asynchronous active-low reset
// s    : decode_queue_if.slave (fetch handshake, rf read addresses, issue handshake, flush, count)
module decode_queue #(
  parameter int DEPTH    = 2,
  parameter int ENABLE_M = 0
) (
  input logic           clk,
  input logic           rstn,
  decode_queue_if.slave s
);
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  kind;
    logic [2:0]  f3;
    logic        alt;
    logic        mext;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } rec_t;
  logic [31:0] w_ins;
  logic [6:0]  w_op;
  logic [6:0]  w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_i, w_s, w_b, w_u, w_j, w_imm;
  logic [3:0]  w_kind;
  logic        w_ill;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  rec_t        w_rec;
  rec_t        w_head;
  logic        w_push, w_pop;
  logic [1:0]  w_wp_nx, w_rp_nx;
  rec_t        r_q [4];
  logic [1:0]  r_wp, r_rp;
  logic [2:0]  r_count;
  assign w_ins = s.in_instr;
  assign w_op  = w_ins[6:0];
  assign w_f3  = w_ins[14:12];
  assign w_f7  = w_ins[31:25];
  assign w_i   = {{20{w_ins[31]}}, w_ins[31:20]};
  assign w_s   = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
  assign w_b   = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
  assign w_u   = {w_ins[31:12], 12'b0};
  assign w_j   = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
  // full 7-bit opcode match also rejects compressed encodings (instr[1:0] != 11)
  always_comb begin
    w_kind = 4'd15;
    w_imm  = '0;
    case (w_op)
      7'h33: w_kind = (w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5)) ||
                       (ENABLE_M != 0 && w_f7 == 7'h01)) ? 4'd0 : 4'd15;
      7'h13: begin
        w_kind = ((w_f3 == 3'd1 && w_f7 != 7'h00) ||
                  (w_f3 == 3'd5 && w_f7 != 7'h00 && w_f7 != 7'h20)) ? 4'd15 : 4'd1;
        w_imm  = w_i;
      end
      7'h03: begin
        w_kind = (w_f3 == 3'd3 || w_f3 == 3'd6 || w_f3 == 3'd7) ? 4'd15 : 4'd2;
        w_imm  = w_i;
      end
      7'h23: begin
        w_kind = (w_f3 > 3'd2) ? 4'd15 : 4'd3;
        w_imm  = w_s;
      end
      7'h63: begin
        w_kind = (w_f3 == 3'd2 || w_f3 == 3'd3) ? 4'd15 : 4'd4;
        w_imm  = w_b;
      end
      7'h6f: begin
        w_kind = 4'd5;
        w_imm  = w_j;
      end
      7'h67: begin
        w_kind = (w_f3 != 3'd0) ? 4'd15 : 4'd6;
        w_imm  = w_i;
      end
      7'h37: begin
        w_kind = 4'd7;
        w_imm  = w_u;
      end
      7'h17: begin
        w_kind = 4'd8;
        w_imm  = w_u;
      end
      7'h0f: begin
        w_kind = 4'd9;
        w_imm  = w_i;
      end
      7'h73: begin
        w_kind = 4'd10;
        w_imm  = w_i;
      end
      default: ;
    endcase
  end
  assign w_ill = (w_kind == 4'd15);
  assign w_rd  = (w_ill || w_kind == 4'd3 || w_kind == 4'd4 || w_kind == 4'd9) ? 5'd0 : w_ins[11:7];
  assign w_rs1 = (w_ill || w_kind == 4'd5 || w_kind == 4'd7 || w_kind == 4'd8) ? 5'd0 : w_ins[19:15];
  assign w_rs2 = (w_kind == 4'd0 || w_kind == 4'd3 || w_kind == 4'd4) ? w_ins[24:20] : 5'd0;
  assign w_rec = '{
    pc:   s.in_pc,
    kind: w_kind,
    f3:   w_f3,
    alt:  (w_kind == 4'd0 || (w_kind == 4'd1 && (w_f3 == 3'd1 || w_f3 == 3'd5))) ? w_ins[30] : 1'b0,
    mext: (ENABLE_M != 0) && w_kind == 4'd0 && w_f7 == 7'h01,
    rd:   w_rd,
    rs1:  w_rs1,
    rs2:  w_rs2,
    imm:  w_ill ? 32'd0 : w_imm
  };
  assign s.rf_rs1 = w_rs1;
  assign s.rf_rs2 = w_rs2;
  assign s.in_ready  = (r_count < 3'(DEPTH));
  assign s.out_valid = (r_count != 3'd0);
  assign s.out_count = r_count;
  assign w_push  = s.in_valid & s.in_ready & ~s.flush;
  assign w_pop   = s.out_valid & s.out_ready & ~s.flush;
  assign w_wp_nx = (r_wp == 2'(DEPTH - 1)) ? 2'd0 : r_wp + 2'd1;
  assign w_rp_nx = (r_rp == 2'(DEPTH - 1)) ? 2'd0 : r_rp + 2'd1;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
    end else if (s.flush) begin
      r_count <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
    end else begin
      if (w_push) r_q[r_wp] <= w_rec;
      if (w_push) r_wp <= w_wp_nx;
      if (w_pop) r_rp <= w_rp_nx;
      r_count <= r_count + 3'(w_push) - 3'(w_pop);
    end
  end
  assign w_head       = r_q[r_rp];
  assign s.out_pc     = w_head.pc;
  assign s.out_kind   = w_head.kind;
  assign s.out_funct3 = w_head.f3;
  assign s.out_alt    = w_head.alt;
  assign s.out_mext   = w_head.mext;
  assign s.out_rd     = w_head.rd;
  assign s.out_rs1    = w_head.rs1;
  assign s.out_rs2    = w_head.rs2;
  assign s.out_imm    = w_head.imm;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: scoreboard bench for decode_queue, ENABLE_M=0 and ENABLE_M=1 instances in lockstep
module tb_decode_queue;
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  kind;
    logic [2:0]  f3;
    logic        alt;
    logic        mext;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } rec_t;
  logic clk;
  logic rstn;
  logic rand_rdy, rdy_rand, rdy_fix;
  int   n_tests, n_fail, n_pop;
  rec_t q0[$];
  rec_t q1[$];
  decode_queue_if a();
  decode_queue_if b();
  decode_queue #(.DEPTH(2), .ENABLE_M(0)) u0 (.clk(clk), .rstn(rstn), .s(a));
  decode_queue #(.DEPTH(2), .ENABLE_M(1)) u1 (.clk(clk), .rstn(rstn), .s(b));
  assign a.out_ready = rand_rdy ? rdy_rand : rdy_fix;
  assign b.flush     = a.flush;
  assign b.in_valid  = a.in_valid;
  assign b.in_pc     = a.in_pc;
  assign b.in_instr  = a.in_instr;
  assign b.out_ready = a.out_ready;
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic rec_t mk(input logic [31:0] pc, input logic [3:0] kind, input logic [2:0] f3,
                              input logic alt, input logic mext, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    return '{pc: pc, kind: kind, f3: f3, alt: alt, mext: mext, rd: rd, rs1: rs1, rs2: rs2, imm: imm};
  endfunction
  initial forever begin
    @(posedge clk);
    #1 rdy_rand = 1'($urandom_range(0, 1));
  end
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (a.flush) begin
        q0.delete();
        q1.delete();
      end else if (a.out_valid && a.out_ready) begin
        n_pop++;
        if (q0.size() == 0 || q1.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          chk("rec_m0", {a.out_pc, a.out_kind, a.out_funct3, a.out_alt, a.out_mext,
                         a.out_rd, a.out_rs1, a.out_rs2, a.out_imm}, q0.pop_front());
          chk("rec_m1", {b.out_pc, b.out_kind, b.out_funct3, b.out_alt, b.out_mext,
                         b.out_rd, b.out_rs1, b.out_rs2, b.out_imm}, q1.pop_front());
        end
      end
    end
  end
  task automatic send(input logic [31:0] pc, input logic [31:0] ins, input rec_t e0, input rec_t e1);
    int t = 0;
    a.in_valid = 1;
    a.in_pc    = pc;
    a.in_instr = ins;
    @(negedge clk);
    while (!a.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!a.in_ready) chk("send_timeout", 0, 1);
    else if (!a.flush) begin
      q0.push_back(e0);
      q1.push_back(e1);
    end
    @(posedge clk);
    #1 a.in_valid = 0;
  endtask
  task automatic wait_empty();
    int t = 0;
    while ((q0.size() != 0 || a.out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", (q0.size() != 0 || a.out_valid), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic gen(input int i, output logic [31:0] ins, output rec_t e);
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [11:0] i12;
    logic [12:0] i13;
    logic [19:0] i20;
    logic [20:0] i21;
    pc  = 32'h1000 + 32'(i * 4);
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    f3  = 3'($urandom);
    alt = 1'($urandom);
    i12 = 12'($urandom);
    i13 = {12'($urandom), 1'b0};
    i20 = 20'($urandom);
    i21 = {20'($urandom), 1'b0};
    case ($urandom_range(0, 8))
      0: begin
        alt = (f3 == 3'd0 || f3 == 3'd5) ? alt : 1'b0;
        ins = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'h33};
        e   = mk(pc, 0, f3, alt, 0, rd, rs1, rs2, 0);
      end
      1: begin
        f3  = (f3 == 3'd1 || f3 == 3'd5) ? 3'd0 : f3;
        ins = {i12, rs1, f3, rd, 7'h13};
        e   = mk(pc, 1, f3, 0, 0, rd, rs1, 0, {{20{i12[11]}}, i12});
      end
      2: begin
        f3  = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? 3'd2 : f3;
        ins = {i12, rs1, f3, rd, 7'h03};
        e   = mk(pc, 2, f3, 0, 0, rd, rs1, 0, {{20{i12[11]}}, i12});
      end
      3: begin
        f3  = 3'($urandom_range(0, 2));
        ins = {i12[11:5], rs2, rs1, f3, i12[4:0], 7'h23};
        e   = mk(pc, 3, f3, 0, 0, 0, rs1, rs2, {{20{i12[11]}}, i12});
      end
      4: begin
        f3  = (f3 == 3'd2 || f3 == 3'd3) ? 3'd0 : f3;
        ins = {i13[12], i13[10:5], rs2, rs1, f3, i13[4:1], i13[11], 7'h63};
        e   = mk(pc, 4, f3, 0, 0, 0, rs1, rs2, {{19{i13[12]}}, i13});
      end
      5: begin
        ins = {i20, rd, 7'h37};
        e   = mk(pc, 7, i20[2:0], 0, 0, rd, 0, 0, {i20, 12'b0});
      end
      6: begin
        ins = {i21[20], i21[10:1], i21[11], i21[19:12], rd, 7'h6f};
        e   = mk(pc, 5, i21[14:12], 0, 0, rd, 0, 0, {{11{i21[20]}}, i21});
      end
      7: begin
        ins = {i12, rs1, 3'b0, rd, 7'h67};
        e   = mk(pc, 6, 0, 0, 0, rd, rs1, 0, {{20{i12[11]}}, i12});
      end
      default: begin
        f3  = alt ? 3'd1 : 3'd5;
        alt = (f3 == 3'd5) ? 1'($urandom) : 1'b0;
        ins = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'h13};
        e   = mk(pc, 1, f3, alt, 0, rd, rs1, 0, {21'b0, alt, 5'b0, rs2});
      end
    endcase
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    logic [31:0] ins;
    rec_t        e;
    time         t0;
    int          p0;
    n_tests  = 0;
    n_fail   = 0;
    n_pop    = 0;
    rand_rdy = 0;
    rdy_fix  = 0;
    rstn     = 0;
    a.flush    = 0;
    a.in_valid = 0;
    a.in_pc    = 0;
    a.in_instr = 0;
    #1;
    chk("rst_valid", a.out_valid, 0);
    chk("rst_count", a.out_count, 0);
    chk("rst_pc", a.out_pc, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    chk("rst_ready", a.in_ready, 1);
    @(posedge clk);
    #1 rdy_fix = 1;
    send(32'h100, 32'hFFF08293, mk(32'h100, 1, 0, 0, 0, 5, 1, 0, 32'hFFFFFFFF),
                                mk(32'h100, 1, 0, 0, 0, 5, 1, 0, 32'hFFFFFFFF));
    chk("rf_rs1", a.rf_rs1, 1);
    chk("rf_rs2", a.rf_rs2, 0);
    @(negedge clk);
    chk("lat_valid", a.out_valid, 1);
    chk("lat_pc", a.out_pc, 32'h100);
    wait_empty();
    rdy_fix = 0;
    send(32'h200, 32'hFE208EE3, mk(32'h200, 4, 0, 0, 0, 0, 1, 2, 32'hFFFFFFFC),
                                mk(32'h200, 4, 0, 0, 0, 0, 1, 2, 32'hFFFFFFFC));
    send(32'h204, 32'h00312423, mk(32'h204, 3, 2, 0, 0, 0, 2, 3, 32'h8),
                                mk(32'h204, 3, 2, 0, 0, 0, 2, 3, 32'h8));
    fork
      send(32'h208, 32'h000010EF, mk(32'h208, 5, 1, 0, 0, 1, 0, 0, 32'h1000),
                                  mk(32'h208, 5, 1, 0, 0, 1, 0, 0, 32'h1000));
      begin
        repeat (3) begin
          @(negedge clk);
          chk("held_ready", a.in_ready, 0);
          chk("held_count", a.out_count, 2);
          chk("held_pc", a.out_pc, 32'h200);
          chk("held_imm", a.out_imm, 32'hFFFFFFFC);
        end
        @(posedge clk);
        #1 rdy_fix = 1;
      end
    join
    wait_empty();
    send(32'h300, 32'h023100B3, mk(32'h300, 15, 0, 0, 0, 0, 0, 0, 0),
                                mk(32'h300, 0, 0, 0, 1, 1, 2, 3, 0));
    send(32'h304, 32'h00008082, mk(32'h304, 15, 0, 0, 0, 0, 0, 0, 0),
                                mk(32'h304, 15, 0, 0, 0, 0, 0, 0, 0));
    send(32'h308, 32'h0000B083, mk(32'h308, 15, 3, 0, 0, 0, 0, 0, 0),
                                mk(32'h308, 15, 3, 0, 0, 0, 0, 0, 0));
    send(32'h30C, 32'h403100B3, mk(32'h30C, 0, 0, 1, 0, 1, 2, 3, 0),
                                mk(32'h30C, 0, 0, 1, 0, 1, 2, 3, 0));
    send(32'h310, 32'h403110B3, mk(32'h310, 15, 1, 0, 0, 0, 0, 0, 0),
                                mk(32'h310, 15, 1, 0, 0, 0, 0, 0, 0));
    wait_empty();
    t0 = $time;
    for (int i = 0; i < 4; i++)
      send(32'h380 + 32'(i * 4), 32'hFFF08293,
           mk(32'h380 + 32'(i * 4), 1, 0, 0, 0, 5, 1, 0, 32'hFFFFFFFF),
           mk(32'h380 + 32'(i * 4), 1, 0, 0, 0, 5, 1, 0, 32'hFFFFFFFF));
    chk("throughput_cycles", 96'(($time - t0) / 10), 4);
    wait_empty();
    for (int n = 1; n <= 2; n++) begin
      rdy_fix = 0;
      for (int k = 0; k < n; k++)
        send(32'h400 + 32'(k * 4), 32'h00000013, mk(32'h400 + 32'(k * 4), 1, 0, 0, 0, 0, 0, 0, 0),
                                                  mk(32'h400 + 32'(k * 4), 1, 0, 0, 0, 0, 0, 0, 0));
      a.in_valid = 1;
      a.in_pc    = 32'h500;
      a.in_instr = 32'h000010EF;
      a.flush    = 1;
      rdy_fix    = 1;
      @(negedge clk);
      chk("flush_ready_same_cycle", a.in_ready, (n < 2));
      @(posedge clk);
      #1;
      a.flush    = 0;
      a.in_valid = 0;
      rdy_fix    = 0;
      @(negedge clk);
      chk("flush_valid", a.out_valid, 0);
      chk("flush_count", a.out_count, 0);
      chk("flush_ready", a.in_ready, 1);
      @(negedge clk);
      chk("flush_no_push", a.out_valid, 0);
      @(posedge clk);
      #1;
    end
    send(32'h600, 32'h00000013, mk(32'h600, 1, 0, 0, 0, 0, 0, 0, 0), mk(32'h600, 1, 0, 0, 0, 0, 0, 0, 0));
    send(32'h604, 32'h00000013, mk(32'h604, 1, 0, 0, 0, 0, 0, 0, 0), mk(32'h604, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("pre_rst_count", a.out_count, 2);
    #2 rstn = 0;
    #1;
    chk("mid_rst_valid", a.out_valid, 0);
    chk("mid_rst_count", a.out_count, 0);
    chk("mid_rst_pc", a.out_pc, 0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    chk("post_rst_ready", a.in_ready, 1);
    chk("post_rst_valid", a.out_valid, 0);
    @(posedge clk);
    #1;
    p0 = n_pop;
    rand_rdy = 1;
    for (int i = 0; i < 100; i++) begin
      gen(i, ins, e);
      send(e.pc, ins, e, e);
    end
    rand_rdy = 0;
    rdy_fix  = 1;
    wait_empty();
    chk("rand_left", q0.size(), 0);
    chk("rand_pops", n_pop - p0, 100);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
